conv_window_feeder: RTL
=======================

// Module: conv_window_feeder
// PURPOSE
//  Upstream stage of the 3x3 mac conv core. Accepts one packed column per beat:
//  3 pixels, one per kernel row, plus 3 weight nibbles. Shifts each column into
//  a 3x3 window register and presents the window as im1..im9 / ker1..ker9.
//  Outputs ROW_LEN-2 windows per strip, with a valid/ready handshake on both sides.
// PARAMETERS
//  IMG_W    8    pixel width
//  KER_W    4    weight width
//  ROW_LEN  128  columns per strip; must be >= 3
//  CNT_W    17   width of column and window counters
// PORTS
//  clk          in   1        system clock
//  i_rst_n      in   1        async active-low reset
//  i_flush      in   1        sync abort: drop the partial window, restart the strip
//  i_valid      in   1        upstream column valid
//  o_ready      out  1        column accepted when i_valid && o_ready
//  i_col_img    in   24       pixels: row1 [7:0], row2 [15:8], row3 [23:16]
//  i_col_wgt    in   24       weights: row1 [3:0], row2 [11:8], row3 [19:16]; other bits ignored
//  i_ready      in   1        downstream (mac) can take the window; mac i_inhibit = ~i_ready
//  o_valid      out  1        window on o_im*/o_ker* is complete
//  o_im1..o_im9 out  IMG_W    window: 1-3 row1 (oldest..newest), 4-6 row2, 7-9 row3
//  o_ker1..o_ker9 out KER_W   same layout as o_im*
//  o_last       out  1        qualifies o_valid: last window of the strip
//  o_win_cnt    out  CNT_W    total handshaken windows; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, i_rst_n=0)
//   - All window regs, o_valid, o_last, o_win_cnt = 0; col_cnt = 0; state = FILL0.
//   - o_ready = 1 from the first edge after release.
//  Readiness and beats
//   - o_ready = ~o_valid | i_ready (combinational). The window is the only storage.
//   - accept = i_valid & o_ready. take = o_valid & i_ready.
//  On accept
//   - Every row shifts left: im1<=im2, im2<=im3, im3<=row1 pixel; same for rows 2/3 and ker.
//   - col_cnt increments.
//  State machine
//   - FILL0 -accept-> FILL1 -accept-> RUN. o_valid <= 0 in both FILL transitions.
//   - RUN: accept -> o_valid <= 1; take without accept -> o_valid <= 0; otherwise hold.
//  Timing and strip boundary
//   - The window containing a column appears on the edge that accepts it.
//   - Latency column->window: 1 cycle. Throughput: 1 window/cycle when i_valid & i_ready stay high.
//   - Accept with col_cnt==ROW_LEN-1: o_last <= 1 with that window; col_cnt -> 0; state -> FILL0.
//   - Columns 0,1 of the next strip make no window; the old window is not reused.
//   - o_last clears with o_valid.
//  Stall and counting
//   - o_valid & ~i_ready: o_ready=0; window, o_last and o_valid hold stable (no drop, no overwrite).
//   - take increments o_win_cnt; accept and take in the same cycle are legal (replace).
//  Flush and abort
//   - i_flush overrides accept/take that cycle.
//   - Effect: state FILL0, col_cnt 0, o_valid 0, o_last 0, window regs 0; o_win_cnt kept.
//   - Async reset mid-strip: full restart. No partial window is emitted.
//  Arithmetic
//   - No arithmetic on data; pixel and weight bits are passed through unchanged.
//   - Weight bits outside the nibble fields are discarded.
// STRUCTURE
//  conv_feed_pkg
//   - State enum {FILL0,FILL1,RUN}.
//   - Field offsets: IMG_ROW_OFS = 0/8/16, KER_ROW_OFS = 0/8/16.
//  Sub-module win_row_shift #(W)
//   - 3-deep enabled shift register for one row.
//   - Instanced 6x: 3 rows x {img, ker}.
//   - Top holds the FSM, col_cnt, handshake and o_win_cnt.
// TESTING
//  1. Reset, then ramp columns (img 0x030201+k, wgt 0x030201) with i_ready=1.
//     -> First o_valid 1 cycle after the 3rd accept: o_im1..3 = 01,02,03, o_ker1..3 = 1,1,1.
//  2. ROW_LEN=128 stream of 256 columns, no stalls.
//     -> 252 windows, 126 per strip; o_last on windows 126 and 252.
//     -> No window spans strips; o_win_cnt = 252.
//  3. i_ready=0 for 5 cycles mid-strip with i_valid=1.
//     -> o_ready=0 and window stable for those 5 cycles; no column lost; window order intact.
//  4. i_valid gaps (1-on/2-off).
//     -> o_valid drops after each take; windows match golden 3x3 sums through mac (i_q=17).
//  5. i_flush at column 60.
//     -> o_valid=0 next cycle; next windows start after 2 new columns; o_win_cnt unchanged.
//  6. i_rst_n low mid-RUN while o_valid=1.
//     -> All outputs 0 immediately (async); restart yields a correct first window.

Source files
------------

// File: rtl/conv_feed_pkg.sv
// Shared types and column field offsets for the conv window feeder.
package conv_feed_pkg;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Bit offset of each kernel row inside the packed column words.
  localparam int IMG_ROW_OFS [3] = '{0, 8, 16};
  localparam int KER_ROW_OFS [3] = '{0, 8, 16};

endpackage

// File: rtl/conv_window_feeder_win_row_shift.sv
// One row of the 3x3 window: a 3-deep enabled shift register, oldest on o_q1.
module win_row_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q1,
  output logic [W-1:0] o_q2,
  output logic [W-1:0] o_q3
);

  logic [W-1:0] q1_q, q1_d;
  logic [W-1:0] q2_q, q2_d;
  logic [W-1:0] q3_q, q3_d;

  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    q3_d = q3_q;
    if (i_clr) begin
      q1_d = '0;
      q2_d = '0;
      q3_d = '0;
    end else if (i_en) begin
      q1_d = q2_q;
      q2_d = q3_q;
      q3_d = i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
      q3_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
      q3_q <= q3_d;
    end
  end

  assign o_q1 = q1_q;
  assign o_q2 = q2_q;
  assign o_q3 = q3_q;

endmodule

// File: rtl/conv_window_feeder.sv
// Builds 3x3 pixel/weight windows from a column stream, ROW_LEN-2 windows per strip.
module conv_window_feeder
  import conv_feed_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int KER_W   = 4,
  parameter int ROW_LEN = 128,
  parameter int CNT_W   = 17
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [23:0]      i_col_img,
  input  logic [23:0]      i_col_wgt,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [IMG_W-1:0] o_im1,
  output logic [IMG_W-1:0] o_im2,
  output logic [IMG_W-1:0] o_im3,
  output logic [IMG_W-1:0] o_im4,
  output logic [IMG_W-1:0] o_im5,
  output logic [IMG_W-1:0] o_im6,
  output logic [IMG_W-1:0] o_im7,
  output logic [IMG_W-1:0] o_im8,
  output logic [IMG_W-1:0] o_im9,
  output logic [KER_W-1:0] o_ker1,
  output logic [KER_W-1:0] o_ker2,
  output logic [KER_W-1:0] o_ker3,
  output logic [KER_W-1:0] o_ker4,
  output logic [KER_W-1:0] o_ker5,
  output logic [KER_W-1:0] o_ker6,
  output logic [KER_W-1:0] o_ker7,
  output logic [KER_W-1:0] o_ker8,
  output logic [KER_W-1:0] o_ker9,
  output logic             o_last,
  output logic [CNT_W-1:0] o_win_cnt,
  output state_t           o_dbg_state
);

  // Handshake: a column moves on i_valid & o_ready, a window on o_valid & i_ready.
  // o_ready = ~o_valid | i_ready, since the window is the only storage; a flush
  // suppresses both beats in its cycle.

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             accept, take, col_last;
  logic [IMG_W-1:0] im_w  [9];
  logic [KER_W-1:0] ker_w [9];
  logic             unused_wgt;

  assign o_ready  = ~valid_q | i_ready;
  assign accept   = i_valid & o_ready & ~i_flush;
  assign take     = valid_q & i_ready & ~i_flush;
  assign col_last = (col_cnt_q == CNT_W'(ROW_LEN - 1));

  for (genvar r = 0; r < 3; r++) begin : g_row
    win_row_shift #(.W(IMG_W)) u_img (
      .clk   (clk),
      .rst_n (i_rst_n),
      .i_clr (i_flush),
      .i_en  (accept),
      .i_din (i_col_img[IMG_ROW_OFS[r] +: IMG_W]),
      .o_q1  (im_w[3*r]),
      .o_q2  (im_w[3*r+1]),
      .o_q3  (im_w[3*r+2])
    );
    win_row_shift #(.W(KER_W)) u_ker (
      .clk   (clk),
      .rst_n (i_rst_n),
      .i_clr (i_flush),
      .i_en  (accept),
      .i_din (i_col_wgt[KER_ROW_OFS[r] +: KER_W]),
      .o_q1  (ker_w[3*r]),
      .o_q2  (ker_w[3*r+1]),
      .o_q3  (ker_w[3*r+2])
    );
  end

  assign unused_wgt = ^{i_col_wgt[7:4], i_col_wgt[15:12], i_col_wgt[23:20]};

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    win_cnt_d = win_cnt_q;
    valid_d   = valid_q;
    last_d    = last_q;
    if (i_flush) begin
      state_d   = FILL0;
      col_cnt_d = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
    end else begin
      if (take) begin
        valid_d   = 1'b0;
        last_d    = 1'b0;
        win_cnt_d = win_cnt_q + CNT_W'(1);
      end
      if (accept) begin
        col_cnt_d = col_last ? '0 : col_cnt_q + CNT_W'(1);
        unique case (state_q)
          FILL0: begin
            state_d = FILL1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
          FILL1: begin
            state_d = RUN;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
          RUN: begin
            valid_d = 1'b1;
            last_d  = col_last;
            if (col_last) state_d = FILL0;
          end
          default: state_d = FILL0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FILL0;
      col_cnt_q <= '0;
      win_cnt_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      win_cnt_q <= win_cnt_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_last      = last_q;
  assign o_win_cnt   = win_cnt_q;
  assign o_dbg_state = state_q;

  assign o_im1 = im_w[0];
  assign o_im2 = im_w[1];
  assign o_im3 = im_w[2];
  assign o_im4 = im_w[3];
  assign o_im5 = im_w[4];
  assign o_im6 = im_w[5];
  assign o_im7 = im_w[6];
  assign o_im8 = im_w[7];
  assign o_im9 = im_w[8];

  assign o_ker1 = ker_w[0];
  assign o_ker2 = ker_w[1];
  assign o_ker3 = ker_w[2];
  assign o_ker4 = ker_w[3];
  assign o_ker5 = ker_w[4];
  assign o_ker6 = ker_w[5];
  assign o_ker7 = ker_w[6];
  assign o_ker8 = ker_w[7];
  assign o_ker9 = ker_w[8];

endmodule
